// File: rtl/id_ex_reg.sv
//
// id_ex_reg
// ---------
// Pipeline register between the decode (ID) and execute (EX) stages.
// On every rising clock edge the decode-stage bundle is copied into the
// execute-stage registers unless the stage is reset, flushed or stalled.
// Control bits are masked to zero whenever the captured slot is not a
// real, legal instruction. A bubble (empty execute slot) is then counted
// by a saturating 16-bit counter.
//
// Parameters
//   DW          datapath width of operands, immediate and PC+4
//   AW          register-address width
//   BUBBLE_RST  value loaded into bubble_cnt on reset. Keep it at 0 in
//               real use. A test bench may set it close to 16'hFFFF so the
//               saturation path can be reached without tens of thousands
//               of flushes.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous active-high reset (highest priority)
//   flush        insert a bubble this cycle (wins over stall)
//   stall        hold every execute-stage output this cycle
//   valid_d      decode stage holds a real instruction
//   illegal_d    decoder saw an unsupported opcode (ctrl_d is don't-care)
//   ctrl_d[9:0]  {branch, jump, reg_dst, we_reg, alu_src, we_dm, dm2reg,
//                 alu_op[1:0], jal}
//   rd1_d/rd2_d  register-file read data A/B
//   imm_d        sign-extended immediate
//   pc4_d        PC+4 of the decode instruction (jal link value)
//   rs_d/rt_d/rd_d  source, target and destination register indices
//   *_e          registered execute-stage copies of the *_d inputs
//   illegal_e    asserted while an illegal instruction sits in execute
//   bubble_cnt   saturating count of bubbles inserted since reset
//
// Every output comes straight from a flop, so there is no combinational
// path from any input to any output.

module id_ex_reg #(
   parameter int          DW         = 32,
   parameter int          AW         = 5,
   parameter logic [15:0] BUBBLE_RST = 16'h0000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          stall,
   input  logic          flush,
   input  logic          valid_d,
   input  logic          illegal_d,
   input  logic [9:0]    ctrl_d,
   input  logic [DW-1:0] rd1_d,
   input  logic [DW-1:0] rd2_d,
   input  logic [DW-1:0] imm_d,
   input  logic [DW-1:0] pc4_d,
   input  logic [AW-1:0] rs_d,
   input  logic [AW-1:0] rt_d,
   input  logic [AW-1:0] rd_d,
   output logic          valid_e,
   output logic          illegal_e,
   output logic [9:0]    ctrl_e,
   output logic [DW-1:0] rd1_e,
   output logic [DW-1:0] rd2_e,
   output logic [DW-1:0] imm_e,
   output logic [DW-1:0] pc4_e,
   output logic [AW-1:0] rs_e,
   output logic [AW-1:0] rt_e,
   output logic [AW-1:0] rd_e,
   output logic [15:0]   bubble_cnt
);

   // A slot carries live control only when the decoder produced a real
   // instruction that it also understood.
   logic        legal_d;
   logic [15:0] bubble_next;

   // The next value of the bubble counter sticks at all-ones instead of
   // wrapping, so a long-running core never reports a misleading small
   // count.
   always_comb begin
      legal_d     = valid_d & ~illegal_d;
      bubble_next = bubble_cnt;
      if (bubble_cnt != 16'hFFFF) begin
         bubble_next = bubble_cnt + 16'd1;
      end
   end

   // Stage register. Priority is reset, then flush, then stall, then a
   // normal capture.
   //
   // Flush clears data as well as control, so a squashed instruction
   // leaves nothing behind in execute.
   //
   // A non-legal capture still copies the data fields, but control is
   // forced to zero. The ternary selects a constant 0, which means an X
   // on ctrl_d (allowed when the instruction is illegal) cannot reach
   // ctrl_e.
   //
   // illegal_e is rewritten on every capture or flush. It therefore
   // lasts exactly one non-stalled cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_e    <= 1'b0;
         illegal_e  <= 1'b0;
         ctrl_e     <= '0;
         rd1_e      <= '0;
         rd2_e      <= '0;
         imm_e      <= '0;
         pc4_e      <= '0;
         rs_e       <= '0;
         rt_e       <= '0;
         rd_e       <= '0;
         bubble_cnt <= BUBBLE_RST;
      end else if (flush) begin
         valid_e    <= 1'b0;
         illegal_e  <= 1'b0;
         ctrl_e     <= '0;
         rd1_e      <= '0;
         rd2_e      <= '0;
         imm_e      <= '0;
         pc4_e      <= '0;
         rs_e       <= '0;
         rt_e       <= '0;
         rd_e       <= '0;
         bubble_cnt <= bubble_next;
      end else if (!stall) begin
         valid_e    <= legal_d;
         illegal_e  <= valid_d & illegal_d;
         ctrl_e     <= legal_d ? ctrl_d : 10'b0;
         rd1_e      <= rd1_d;
         rd2_e      <= rd2_d;
         imm_e      <= imm_d;
         pc4_e      <= pc4_d;
         rs_e       <= rs_d;
         rt_e       <= rt_d;
         rd_e       <= rd_d;
         if (!legal_d) begin
            bubble_cnt <= bubble_next;
         end
      end
   end

endmodule

// File: tb/tb_id_ex_reg.sv
//
// tb_id_ex_reg
// ------------
// Directed test bench for id_ex_reg. Each task drives one scenario and
// compares the execute-stage outputs against hand-computed values.
//
// A second instance (sat_dut) shares all inputs with the main instance.
// Its counter reset value is preloaded to 16'hFFFD so that counter
// saturation can be reached with only a few flushes.

module tb_id_ex_reg;

   localparam int DW = 32;
   localparam int AW = 5;

   localparam logic [9:0] CTRL_RTYPE = 10'b0011000100;
   localparam logic [9:0] CTRL_LW    = 10'b0001101000;
   localparam logic [9:0] CTRL_SW    = 10'b0000110000;
   localparam logic [9:0] CTRL_JAL   = 10'b0101000001;

   logic          clk;
   logic          rst;
   logic          stall;
   logic          flush;
   logic          valid_d;
   logic          illegal_d;
   logic [9:0]    ctrl_d;
   logic [DW-1:0] rd1_d, rd2_d, imm_d, pc4_d;
   logic [AW-1:0] rs_d, rt_d, rd_d;

   logic          valid_e, illegal_e;
   logic [9:0]    ctrl_e;
   logic [DW-1:0] rd1_e, rd2_e, imm_e, pc4_e;
   logic [AW-1:0] rs_e, rt_e, rd_e;
   logic [15:0]   bubble_cnt;

   logic          s_valid_e, s_illegal_e;
   logic [9:0]    s_ctrl_e;
   logic [DW-1:0] s_rd1_e, s_rd2_e, s_imm_e, s_pc4_e;
   logic [AW-1:0] s_rs_e, s_rt_e, s_rd_e;
   logic [15:0]   s_bubble_cnt;

   int checks   = 0;
   int failures = 0;

   id_ex_reg #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .valid_d(valid_d), .illegal_d(illegal_d), .ctrl_d(ctrl_d),
      .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d), .pc4_d(pc4_d),
      .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
      .valid_e(valid_e), .illegal_e(illegal_e), .ctrl_e(ctrl_e),
      .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e), .pc4_e(pc4_e),
      .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e), .bubble_cnt(bubble_cnt)
   );

   id_ex_reg #(.DW(DW), .AW(AW), .BUBBLE_RST(16'hFFFD)) sat_dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .valid_d(valid_d), .illegal_d(illegal_d), .ctrl_d(ctrl_d),
      .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d), .pc4_d(pc4_d),
      .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
      .valid_e(s_valid_e), .illegal_e(s_illegal_e), .ctrl_e(s_ctrl_e),
      .rd1_e(s_rd1_e), .rd2_e(s_rd2_e), .imm_e(s_imm_e), .pc4_e(s_pc4_e),
      .rs_e(s_rs_e), .rt_e(s_rt_e), .rd_e(s_rd_e), .bubble_cnt(s_bubble_cnt)
   );

   // Free-running clock with a 10 ns period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive the decode-stage inputs on the falling edge, away from the
   // capturing edge.
   task automatic set_inputs(input logic v, input logic il, input logic [9:0] c,
                             input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [DW-1:0] im, input logic [DW-1:0] p,
                             input logic [AW-1:0] s, input logic [AW-1:0] t,
                             input logic [AW-1:0] d);
      @(negedge clk);
      valid_d = v; illegal_d = il; ctrl_d = c;
      rd1_d = a; rd2_d = b; imm_d = im; pc4_d = p;
      rs_d = s; rt_d = t; rd_d = d;
   endtask

   // Advance past one rising edge and settle 1 ns before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      set_inputs(1'b1, 1'b0, CTRL_RTYPE, 32'h1, 32'h2, 32'h3, 32'h4, 5'd1, 5'd2, 5'd3);
      rst = 1'b1; flush = 1'b1; stall = 1'b1;
      tick();
      checks++; if (valid_e !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", valid_e); end
      checks++; if (illegal_e !== 1'b0) begin failures++; $display("[TB] FAIL reset_illegal got=%b exp=0", illegal_e); end
      checks++; if (ctrl_e !== 10'b0) begin failures++; $display("[TB] FAIL reset_ctrl got=%b exp=0", ctrl_e); end
      checks++; if ({rd1_e, rd2_e, imm_e, pc4_e} !== 128'b0) begin failures++; $display("[TB] FAIL reset_data got=%h %h %h %h exp=0", rd1_e, rd2_e, imm_e, pc4_e); end
      checks++; if ({rs_e, rt_e, rd_e} !== 15'b0) begin failures++; $display("[TB] FAIL reset_idx got=%h %h %h exp=0", rs_e, rt_e, rd_e); end
      checks++; if (bubble_cnt !== 16'h0) begin failures++; $display("[TB] FAIL reset_bubble got=%h exp=0000", bubble_cnt); end
      checks++; if (s_bubble_cnt !== 16'hFFFD) begin failures++; $display("[TB] FAIL reset_sat_bubble got=%h exp=fffd", s_bubble_cnt); end
      @(negedge clk);
      rst = 1'b0; flush = 1'b0; stall = 1'b0;
   endtask

   // R-type capture: all fields appear one edge later.
   task automatic test_capture();
      set_inputs(1'b1, 1'b0, CTRL_RTYPE, 32'h5, 32'hA5A5_0001, 32'hFFFF_FFF0, 32'h0040_0004, 5'd7, 5'd8, 5'd9);
      tick();
      checks++; if (ctrl_e !== CTRL_RTYPE) begin failures++; $display("[TB] FAIL cap_ctrl got=%b exp=%b", ctrl_e, CTRL_RTYPE); end
      checks++; if (rd1_e !== 32'h5) begin failures++; $display("[TB] FAIL cap_rd1 got=%h exp=00000005", rd1_e); end
      checks++; if (valid_e !== 1'b1) begin failures++; $display("[TB] FAIL cap_valid got=%b exp=1", valid_e); end
      checks++; if ({rd2_e, imm_e, pc4_e} !== {32'hA5A5_0001, 32'hFFFF_FFF0, 32'h0040_0004}) begin failures++; $display("[TB] FAIL cap_data got=%h %h %h", rd2_e, imm_e, pc4_e); end
      checks++; if ({rs_e, rt_e, rd_e} !== {5'd7, 5'd8, 5'd9}) begin failures++; $display("[TB] FAIL cap_idx got=%0d %0d %0d exp=7 8 9", rs_e, rt_e, rd_e); end
      checks++; if (illegal_e !== 1'b0) begin failures++; $display("[TB] FAIL cap_illegal got=%b exp=0", illegal_e); end
      checks++; if (bubble_cnt !== 16'd0) begin failures++; $display("[TB] FAIL cap_bubble got=%0d exp=0", bubble_cnt); end
   endtask

   // LW capture followed by three stalled cycles with different inputs.
   task automatic test_stall();
      set_inputs(1'b1, 1'b0, CTRL_LW, 32'h1000, 32'h0, 32'h8, 32'h0040_0008, 5'd4, 5'd5, 5'd0);
      tick();
      checks++; if (ctrl_e !== CTRL_LW) begin failures++; $display("[TB] FAIL lw_ctrl got=%b exp=%b", ctrl_e, CTRL_LW); end
      for (int i = 0; i < 3; i++) begin
         set_inputs(1'b1, 1'b0, CTRL_JAL, 32'hDEAD_0000 + i, 32'h1, 32'h2, 32'h3, 5'd31, 5'd30, 5'd29);
         stall = 1'b1;
         tick();
         checks++; if (ctrl_e !== CTRL_LW) begin failures++; $display("[TB] FAIL stall_ctrl cyc=%0d got=%b exp=%b", i, ctrl_e, CTRL_LW); end
         checks++; if ({rd1_e, imm_e, pc4_e} !== {32'h1000, 32'h8, 32'h0040_0008}) begin failures++; $display("[TB] FAIL stall_data cyc=%0d got=%h %h %h", i, rd1_e, imm_e, pc4_e); end
         checks++; if ({valid_e, rs_e, rt_e} !== {1'b1, 5'd4, 5'd5}) begin failures++; $display("[TB] FAIL stall_idx cyc=%0d got=%b %0d %0d exp=1 4 5", i, valid_e, rs_e, rt_e); end
         checks++; if (bubble_cnt !== 16'd0) begin failures++; $display("[TB] FAIL stall_bubble cyc=%0d got=%0d exp=0", i, bubble_cnt); end
      end
      stall = 1'b0;
   endtask

   // flush and stall together with an SW in decode: a bubble wins.
   task automatic test_flush_stall();
      set_inputs(1'b1, 1'b0, CTRL_SW, 32'h77, 32'h88, 32'h4, 32'h0040_000C, 5'd2, 5'd3, 5'd0);
      flush = 1'b1; stall = 1'b1;
      tick();
      checks++; if (ctrl_e !== 10'b0) begin failures++; $display("[TB] FAIL flush_ctrl got=%b exp=0", ctrl_e); end
      checks++; if (valid_e !== 1'b0) begin failures++; $display("[TB] FAIL flush_valid got=%b exp=0", valid_e); end
      checks++; if ({rd1_e, rd2_e, rs_e, rt_e} !== 74'b0) begin failures++; $display("[TB] FAIL flush_data got=%h %h %0d %0d exp=0", rd1_e, rd2_e, rs_e, rt_e); end
      checks++; if (bubble_cnt !== 16'd1) begin failures++; $display("[TB] FAIL flush_bubble got=%0d exp=1", bubble_cnt); end
      flush = 1'b0; stall = 1'b0;
   endtask

   // valid_d=0: control masked, data still captured, bubble counted.
   task automatic test_invalid_capture();
      set_inputs(1'b0, 1'b0, CTRL_RTYPE, 32'h1234, 32'h5678, 32'h9, 32'hA, 5'd11, 5'd12, 5'd13);
      tick();
      checks++; if ({valid_e, ctrl_e} !== 11'b0) begin failures++; $display("[TB] FAIL inval_ctrl got=%b %b exp=0", valid_e, ctrl_e); end
      checks++; if ({rd1_e, rd_e} !== {32'h1234, 5'd13}) begin failures++; $display("[TB] FAIL inval_data got=%h %0d exp=00001234 13", rd1_e, rd_e); end
      checks++; if (bubble_cnt !== 16'd2) begin failures++; $display("[TB] FAIL inval_bubble got=%0d exp=2", bubble_cnt); end
   endtask

   // Illegal instruction with X control; illegal_e holds through a stall
   // and clears on the next legal capture.
   task automatic test_illegal();
      set_inputs(1'b1, 1'b1, 10'bx, 32'hBAD, 32'h0, 32'h0, 32'h0040_0010, 5'd1, 5'd1, 5'd1);
      tick();
      checks++; if (ctrl_e !== 10'b0) begin failures++; $display("[TB] FAIL ill_ctrl got=%b exp=0", ctrl_e); end
      checks++; if ({valid_e, illegal_e} !== 2'b01) begin failures++; $display("[TB] FAIL ill_flags got=%b%b exp=01", valid_e, illegal_e); end
      checks++; if (rd1_e !== 32'hBAD) begin failures++; $display("[TB] FAIL ill_rd1 got=%h exp=00000bad", rd1_e); end
      checks++; if (bubble_cnt !== 16'd3) begin failures++; $display("[TB] FAIL ill_bubble got=%0d exp=3", bubble_cnt); end
      set_inputs(1'b1, 1'b0, CTRL_RTYPE, 32'h6, 32'h7, 32'h0, 32'h0040_0014, 5'd6, 5'd7, 5'd8);
      stall = 1'b1;
      tick();
      checks++; if (illegal_e !== 1'b1) begin failures++; $display("[TB] FAIL ill_stall_hold got=%b exp=1", illegal_e); end
      stall = 1'b0;
      tick();
      checks++; if ({valid_e, illegal_e} !== 2'b10) begin failures++; $display("[TB] FAIL ill_clear got=%b%b exp=10", valid_e, illegal_e); end
      checks++; if (ctrl_e !== CTRL_RTYPE) begin failures++; $display("[TB] FAIL ill_next_ctrl got=%b exp=%b", ctrl_e, CTRL_RTYPE); end
      checks++; if (bubble_cnt !== 16'd3) begin failures++; $display("[TB] FAIL legal_no_bubble got=%0d exp=3", bubble_cnt); end
   endtask

   // JAL held by a stall, then reset asserted while still stalled.
   task automatic test_reset_during_stall();
      set_inputs(1'b1, 1'b0, CTRL_JAL, 32'h0, 32'h0, 32'h0010_0000, 32'h0040_0020, 5'd0, 5'd0, 5'd31);
      tick();
      checks++; if ({ctrl_e, pc4_e} !== {CTRL_JAL, 32'h0040_0020}) begin failures++; $display("[TB] FAIL jal_cap got=%b %h", ctrl_e, pc4_e); end
      @(negedge clk);
      stall = 1'b1;
      tick();
      checks++; if (ctrl_e !== CTRL_JAL) begin failures++; $display("[TB] FAIL jal_stall got=%b exp=%b", ctrl_e, CTRL_JAL); end
      @(negedge clk);
      rst = 1'b1;
      tick();
      checks++; if ({valid_e, illegal_e, ctrl_e} !== 12'b0) begin failures++; $display("[TB] FAIL rst_stall_ctrl got=%b %b %b exp=0", valid_e, illegal_e, ctrl_e); end
      checks++; if ({rd1_e, rd2_e, imm_e, pc4_e, rs_e, rt_e, rd_e} !== 143'b0) begin failures++; $display("[TB] FAIL rst_stall_data got=%h %h %0d", imm_e, pc4_e, rd_e); end
      checks++; if (bubble_cnt !== 16'd0) begin failures++; $display("[TB] FAIL rst_stall_bubble got=%0d exp=0", bubble_cnt); end
      @(negedge clk);
      rst = 1'b0; stall = 1'b0;
   endtask

   // Preloaded counter: FFFD -> FFFE -> FFFF -> FFFF across three flushes.
   task automatic test_saturation();
      logic [15:0] exp_sat [3];
      exp_sat[0] = 16'hFFFE; exp_sat[1] = 16'hFFFF; exp_sat[2] = 16'hFFFF;
      checks++; if (s_bubble_cnt !== 16'hFFFD) begin failures++; $display("[TB] FAIL sat_start got=%h exp=fffd", s_bubble_cnt); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         flush = 1'b1;
         tick();
         checks++; if (s_bubble_cnt !== exp_sat[i]) begin failures++; $display("[TB] FAIL sat_flush%0d got=%h exp=%h", i, s_bubble_cnt, exp_sat[i]); end
         checks++; if (bubble_cnt !== 16'(i + 1)) begin failures++; $display("[TB] FAIL main_flush%0d got=%0d exp=%0d", i, bubble_cnt, i + 1); end
      end
      @(negedge clk);
      flush = 1'b0;
      set_inputs(1'b0, 1'b0, 10'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
      tick();
      checks++; if (s_bubble_cnt !== 16'hFFFF) begin failures++; $display("[TB] FAIL sat_bubble_capture got=%h exp=ffff", s_bubble_cnt); end
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      valid_d = 1'b0; illegal_d = 1'b0; ctrl_d = '0;
      rd1_d = '0; rd2_d = '0; imm_d = '0; pc4_d = '0;
      rs_d = '0; rt_d = '0; rd_d = '0;
      test_reset();
      test_capture();
      test_stall();
      test_flush_stall();
      test_invalid_capture();
      test_illegal();
      test_reset_during_stall();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter DW, default 32, datapath width of register-file operands, immediate and PC+4.
REQ-002 Parameter AW, default 5, register-address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hold all stage contents this cycle.
REQ-006 flush  input  1  replace captured instruction with bubble.
REQ-007 valid_d  input  1  decode stage holds a real instruction.
REQ-008 illegal_d  input  1  decoder saw unsupported opcode; ctrl_d is don't-care/X.
REQ-009 ctrl_d  input  10  packed {branch, jump, reg_dst, we_reg, alu_src, we_dm, dm2reg, alu_op[1:0], jal}.
REQ-010 rd1_d  input  DW  register-file read data A.
REQ-011 rd2_d  input  DW  register-file read data B.
REQ-012 imm_d  input  DW  sign-extended immediate.
REQ-013 pc4_d  input  DW  PC+4 of decode instruction (jal link value).
REQ-014 rs_d  input  AW  source register index.
REQ-015 rt_d  input  AW  target register index.
REQ-016 rd_d  input  AW  destination register index.
REQ-017 valid_e, ctrl_e[9:0], rd1_e, rd2_e, imm_e, pc4_e, rs_e, rt_e, rd_e  output  widths as inputs  registered execute-stage copies.
REQ-018 illegal_e  output  1  one-cycle pulse: illegal instruction reached execute.
REQ-019 bubble_cnt  output  16  count of bubbles inserted since reset.

Function
REQ-020 Per rising edge, priority rst > flush > stall > capture.
REQ-021 Capture: every _e output takes its _d input on the same edge; latency exactly one cycle.
REQ-022 Flush: valid_e=0, ctrl_e=0, illegal_e=0; data/index outputs=0; bubble_cnt increments by 1.
REQ-023 flush and stall both high: flush wins (bubble inserted, stall ignored).
REQ-024 Stall (flush low): all outputs including illegal_e hold previous values; bubble_cnt unchanged.
REQ-025 Capture with valid_d=0: valid_e=0, ctrl_e forced to 0 regardless of ctrl_d, data fields captured; bubble_cnt increments.
REQ-026 Capture with valid_d=1 and illegal_d=1: valid_e=0, ctrl_e=0, illegal_e=1 for that cycle; bubble_cnt increments.
REQ-027 illegal_e returns to 0 on next capture/flush; it never remains asserted across two captures.
REQ-028 ctrl_e never carries X: any X on ctrl_d is masked whenever valid_d=0 or illegal_d=1.
REQ-029 Pure legal capture (valid_d=1, illegal_d=0): ctrl_e=ctrl_d bit-exact, valid_e=1.
REQ-030 bubble_cnt saturates at 16'hFFFF; no wrap to 0.
REQ-031 No combinational path from any input to any output.

Reset
REQ-032 rst high at edge: all outputs 0, including valid_e, illegal_e, bubble_cnt; overrides flush/stall.
REQ-033 rst asserted mid-stall: state cleared on that edge; stall has no effect while rst high.

Verification
REQ-034 Reset then valid_d=1, ctrl_d=10'b0011000100 (R-type), rd1_d=32'h5 -> next cycle ctrl_e=10'b0011000100, rd1_e=32'h5, valid_e=1.
REQ-035 Capture LW (ctrl_d=10'b0001101000), then stall=1 for 3 cycles with new inputs -> outputs unchanged all 3 cycles.
REQ-036 flush=1 and stall=1 together with SW ctrl_d -> ctrl_e=0, valid_e=0, bubble_cnt+1.
REQ-037 valid_d=1, illegal_d=1, ctrl_d=X -> ctrl_e=0, valid_e=0, illegal_e=1 one cycle, then 0 after next legal capture.
REQ-038 Force bubble_cnt near max (65535 flushes or preload via test hook) -> one more flush keeps 16'hFFFF.
REQ-039 Assert rst during stall with JAL held (ctrl_e=10'b0101000001) -> all outputs 0 on that edge.
